// File: rtl/conv2x2_host_pkg.sv
// Shared constants and types for the 2x2 convolution core host driver.
// The core's pin-level mode codes and the driver's sequencing states live here.
package conv2x2_host_pkg;

  localparam int NUM_TAPS = 4;
  localparam int BYTE_W   = 8;
  localparam int RES_W    = 9;
  localparam int VEC_W    = NUM_TAPS * BYTE_W;
  localparam int CNT_W    = 2;

  localparam logic [1:0] MODE_IN = 2'b00;
  localparam logic [1:0] MODE_WT = 2'b01;
  localparam logic [1:0] MODE_RD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_I  = 3'd2,
    SETTLE  = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  // Return word is {odd, conv[8]} on the high pins and conv[7:0] on the low pins.
  function automatic logic [RES_W-1:0] pack_result(input logic [BYTE_W-1:0] lo,
                                                   input logic [1:0]        hi);
    return {hi[0], lo};
  endfunction

  function automatic logic odd_mismatch(input logic returned, input logic expected);
    return returned ^ expected;
  endfunction

endpackage

// File: rtl/conv2x2_byte_serializer.sv
// Emits a 32-bit word as four bytes, byte 0 first, as a registered byte stream.
// Shifting in zeros leaves the output at 0 once all bytes have gone out.
module conv2x2_byte_serializer
  import conv2x2_host_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [VEC_W-1:0]  i_vec,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_last
);

  logic [VEC_W-1:0] r_word;
  logic [CNT_W-1:0] r_cnt;

  // Load takes priority so a reload can replace the final shift of the previous word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word <= {VEC_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_word <= i_vec;
      r_cnt  <= {CNT_W{1'b0}};
    end else if (i_shift) begin
      r_word <= {{BYTE_W{1'b0}}, r_word[VEC_W-1:BYTE_W]};
      r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_byte = r_word[BYTE_W-1:0];
  assign o_last = (r_cnt == 2'd3);

endmodule

// File: rtl/conv2x2_host_driver.sv
// Host initiator for the 2x2 convolution core: loads weights/inputs, reads the
// result, and checks the returned odd flag against a locally mirrored copy.
module conv2x2_host_driver
  import conv2x2_host_pkg::*;
#(
  parameter int PIN_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                load_weights,
  input  logic [VEC_W-1:0]    in_vec,
  input  logic [VEC_W-1:0]    wt_vec,
  output logic                busy,
  output logic                done,
  output logic [RES_W-1:0]    result,
  output logic                parity_err,
  output logic [BYTE_W-1:0]   pin_data,
  output logic [1:0]          pin_mode,
  input  logic [BYTE_W-1:0]   pin_res_lo,
  input  logic [1:0]          pin_res_hi
);

  localparam logic [1:0] LAT_L = 2'(PIN_LAT);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_wait, w_wait_nxt;
  logic [1:0]       r_pin_mode, w_mode_nxt;
  logic [VEC_W-1:0] r_in_vec, w_ser_vec;
  logic             w_ser_load, w_ser_shift, w_ser_last;
  logic             w_accept, w_snap_en, w_capture;
  logic             r_exp_odd, r_exp_snap;
  logic             r_busy, r_done, r_parity_err;
  logic [RES_W-1:0] r_result;
  logic [BYTE_W-1:0] w_ser_byte;

  conv2x2_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ser_load),
    .i_shift (w_ser_shift),
    .i_vec   (w_ser_vec),
    .o_byte  (w_ser_byte),
    .o_last  (w_ser_last)
  );

  // Next-state and next pin mode; every non-loading cycle reads so core state is never disturbed.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_mode_nxt  = MODE_RD;
    w_ser_load  = 1'b0;
    w_ser_shift = 1'b0;
    w_ser_vec   = r_in_vec;
    w_accept    = 1'b0;
    w_snap_en   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !r_done) begin
          w_accept   = 1'b1;
          w_ser_load = 1'b1;
          if (load_weights) begin
            w_state_nxt = LOAD_W;
            w_mode_nxt  = MODE_WT;
            w_ser_vec   = wt_vec;
          end else begin
            w_state_nxt = LOAD_I;
            w_mode_nxt  = MODE_IN;
            w_ser_vec   = in_vec;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD_W: begin
        if (w_ser_last) begin
          w_state_nxt = LOAD_I;
          w_mode_nxt  = MODE_IN;
          w_ser_load  = 1'b1;
        end else begin
          w_mode_nxt  = MODE_WT;
          w_ser_shift = 1'b1;
        end
      end
      LOAD_I: begin
        w_ser_shift = 1'b1;
        if (w_ser_last) begin
          w_state_nxt = SETTLE;
          w_wait_nxt  = 2'd0;
        end else begin
          w_mode_nxt  = MODE_IN;
        end
      end
      SETTLE: begin
        // The second read after loading captures the fresh convolution.
        if (r_wait == 2'd1) begin
          w_snap_en   = 1'b1;
          w_state_nxt = CAPTURE;
          w_wait_nxt  = 2'd0;
        end else begin
          w_wait_nxt  = r_wait + 2'd1;
        end
      end
      CAPTURE: begin
        if (r_wait == LAT_L) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt  = r_wait + 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, pin mode, odd mirror and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wait       <= 2'd0;
      r_pin_mode   <= MODE_IN;
      r_in_vec     <= {VEC_W{1'b0}};
      r_exp_odd    <= 1'b0;
      r_exp_snap   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= {RES_W{1'b0}};
      r_parity_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_pin_mode <= w_mode_nxt;
      r_done     <= w_capture;
      if (r_pin_mode == MODE_RD) r_exp_odd <= ~r_exp_odd;
      if (w_snap_en) r_exp_snap <= r_exp_odd;
      if (w_accept) r_in_vec <= in_vec;
      if (w_accept) r_busy <= 1'b1;
      else if (w_capture) r_busy <= 1'b0;
      if (w_capture) begin
        r_result     <= pack_result(pin_res_lo, pin_res_hi);
        r_parity_err <= odd_mismatch(pin_res_hi[1], r_exp_snap);
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign parity_err = r_parity_err;
  assign pin_data   = w_ser_byte;
  assign pin_mode   = r_pin_mode;

endmodule

// File: tb/tb_conv2x2_host_driver.sv
// Drives two host drivers (return-path latency 0 and 2) against a pin-level core
// model and checks results, parity flags and latencies against a request-level reference.
module tb_conv2x2_host_driver;
  import conv2x2_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, load_weights, inject;
  logic [31:0] in_vec, wt_vec;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_wt;

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_conv(input logic [31:0] iv, input logic [31:0] wv);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(iv[8*k +: 8]) * int'(wv[8*k +: 8]);
    return 9'(s % 512);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = 2 * g;
    logic        busy, done, parity_err;
    logic [8:0]  result;
    logic [7:0]  pin_data, res_lo;
    logic [1:0]  pin_mode, res_hi;
    logic [31:0] c_in, c_wt;
    logic [8:0]  c_conv;
    logic        c_odd;
    logic [9:0]  c_out, ret;
    logic [9:0]  c_pipe [0:2];
    int          ndone = 0;

    conv2x2_host_driver #(.PIN_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights),
      .in_vec(in_vec), .wt_vec(wt_vec), .busy(busy), .done(done),
      .result(result), .parity_err(parity_err), .pin_data(pin_data),
      .pin_mode(pin_mode), .pin_res_lo(res_lo), .pin_res_hi(res_hi)
    );

    // Core model: shift on load modes, capture {odd, conv} and toggle odd on reads.
    always @(posedge clk) begin
      if (!rst_n) begin
        c_in <= 32'd0; c_wt <= 32'd0; c_conv <= 9'd0; c_odd <= 1'b0; c_out <= 10'd0;
      end else begin
        case (pin_mode)
          2'b00: c_in <= {pin_data, c_in[31:8]};
          2'b01: c_wt <= {pin_data, c_wt[31:8]};
          2'b10: begin c_out <= {c_odd, c_conv}; c_odd <= ~c_odd; end
          default: ;
        endcase
        c_conv <= ref_conv(c_in, c_wt);
      end
    end

    always @(posedge clk) begin
      c_pipe[0] <= c_out;
      c_pipe[1] <= c_pipe[0];
      c_pipe[2] <= c_pipe[1];
      if (done) ndone <= ndone + 1;
    end

    assign ret    = (LAT == 0) ? c_out : c_pipe[(LAT == 0) ? 0 : LAT - 1];
    assign res_lo = ret[7:0];
    assign res_hi = {ret[9] ^ inject, ret[8]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic [31:0] iv, input logic [31:0] wv,
                         input logic lw, input logic inj, input logic disturb,
                         input logic chk_modes);
    int lat0 = -1;
    int lat1 = -1;
    int n0, n1, exp_lat;
    logic [8:0]  exp_res;
    logic [23:0] modes_obs, modes_exp;
    if (lw) ref_wt = wv;
    exp_res = ref_conv(iv, ref_wt);
    exp_lat = lw ? 11 : 7;
    n0 = lane[0].ndone;
    n1 = lane[1].ndone;
    modes_obs = 24'd0;
    modes_exp = {{4{MODE_RD}}, {4{MODE_IN}}, {4{MODE_WT}}};
    @(negedge clk);
    in_vec = iv; wt_vec = wv; load_weights = lw; inject = inj; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_accept"}, 32'(lane[0].busy), 32'd1);
    modes_obs[1:0] = lane[0].pin_mode;
    for (int c = 1; c <= 40 && (lat0 < 0 || lat1 < 0); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 12) modes_obs[2*c +: 2] = lane[0].pin_mode;
      if (disturb && c >= 2 && c <= 5) begin
        start = 1'b1; in_vec = $urandom; wt_vec = $urandom; load_weights = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (lane[0].done && lat0 < 0) begin
        lat0 = c;
        check({tag, " result0"}, 32'(lane[0].result), 32'(exp_res));
        check({tag, " parity0"}, 32'(lane[0].parity_err), 32'(inj));
        check({tag, " busy0_at_done"}, 32'(lane[0].busy), 32'd0);
      end
      if (lane[1].done && lat1 < 0) begin
        lat1 = c;
        check({tag, " result1"}, 32'(lane[1].result), 32'(exp_res));
        check({tag, " parity1"}, 32'(lane[1].parity_err), 32'(inj));
      end
    end
    check({tag, " latency0"}, 32'(lat0), 32'(exp_lat));
    check({tag, " latency1"}, 32'(lat1), 32'(exp_lat + 2));
    if (chk_modes) check({tag, " pin_mode_seq"}, 32'(modes_obs), 32'(modes_exp));
    inject = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, " done_count0"}, 32'(lane[0].ndone - n0), 32'd1);
    check({tag, " done_count1"}, 32'(lane[1].ndone - n1), 32'd1);
    check({tag, " result_held"}, 32'(lane[0].result), 32'(exp_res));
  endtask

  initial begin
    int n0, n1;
    logic lw;
    rst_n = 1'b0; start = 1'b0; load_weights = 1'b0; inject = 1'b0;
    in_vec = 32'd0; wt_vec = 32'd0; ref_wt = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(lane[0].busy), 32'd0);
    check("rst done", 32'(lane[0].done), 32'd0);
    check("rst result", 32'(lane[0].result), 32'd0);
    check("rst parity", 32'(lane[0].parity_err), 32'd0);
    check("rst pin_data", 32'(lane[0].pin_data), 32'd0);
    check("rst pin_mode", 32'(lane[0].pin_mode), 32'd0);
    rst_n = 1'b1;

    run_req("no_weights_yet", $urandom, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("basic", 32'h04030201, 32'h08070605, 1'b1, 1'b0, 1'b0, 1'b1);
    run_req("reuse_wt", 32'h0000000A, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("all_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_req("parity_inject", 32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0, 1'b0);
    run_req("after_inject", $urandom, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("disturb", $urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);

    // Abort a request with reset in the middle of the input load.
    n0 = lane[0].ndone;
    n1 = lane[1].ndone;
    @(negedge clk);
    in_vec = $urandom; wt_vec = $urandom; load_weights = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort busy", 32'(lane[0].busy), 32'd0);
    check("abort pin_mode", 32'(lane[0].pin_mode), 32'd0);
    check("abort result", 32'(lane[0].result), 32'd0);
    ref_wt = 32'd0;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("abort no_done0", 32'(lane[0].ndone - n0), 32'd0);
    check("abort no_done1", 32'(lane[1].ndone - n1), 32'd0);
    run_req("post_abort", 32'h04030201, 32'h08070605, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      lw = 1'($urandom);
      run_req("random", $urandom, $urandom, lw, 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2x2_host_driver.md
Name: conv2x2_host_driver

Overview:
- Host-side initiator for the 2x2 convolution core's pin interface.
- Accepts a 2x2 input vector and a 2x2 weight vector on a parallel request port, then serializes them into the core's byte/mode protocol.
- Issues the read strobe, captures the 10-bit {odd, conv[8:0]} return word, and checks the odd-toggle flag against a locally mirrored parity.
- Sits in the FPGA test harness or system wrapper, directly driving the core's ui_in/uio_in[7:6] and sampling its uo_out/uio_out[1:0].

Parameters:
- PIN_LAT, 0, extra register stages on the return path (pin_res_*) inserted by the top level; legal range 0..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset; shared with the core
- start  in  1  request strobe; sampled only in IDLE
- load_weights  in  1  1 = load wt_vec before in_vec; 0 = reuse weights already in the core
- in_vec  in  32  input bytes; byte k = in_vec[8k+7:8k]
- wt_vec  in  32  weight bytes; same packing as in_vec
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result and parity_err are valid
- result  out  9  captured conv[8:0], held until the next done
- parity_err  out  1  returned odd bit differed from expected; held with result
- pin_data  out  8  to core ui_in
- pin_mode  out  2  to core {uio_in[7], uio_in[6]}
- pin_res_lo  in  8  from core uo_out
- pin_res_hi  in  2  from core uio_out[1:0]

Behaviour:
- Mode encoding (driven on pin_mode):
  - MODE_IN = 00: core shifts pin_data into inputs.
  - MODE_WT = 01: core shifts pin_data into weights.
  - MODE_RD = 10: core captures outputState and toggles odd.
  - 11 is never driven.
- The core has no hold mode; every cycle has an effect. The driver therefore drives MODE_RD in every cycle it is not loading, so inputs and weights are never disturbed.
- Reset state:
  - Outputs: busy = 0, done = 0, result = 0, parity_err = 0, pin_data = 0, pin_mode = 00 (core is also in reset).
  - Internal: exp_odd = 0, state = IDLE.
- exp_odd toggles on every edge at which the core samples pin_mode = MODE_RD, exactly mirroring the core's odd register.
- FSM states, with start accepted at edge 0:
  - IDLE: pin_mode = MODE_RD, pin_data = 0. When start = 1, go to LOAD_W if load_weights = 1, otherwise go to LOAD_I.
  - LOAD_W: 4 cycles at MODE_WT; pin_data = wt byte 0, 1, 2, 3, sampled by the core at edges 1..4. Byte 0 goes first so that it lands in weights[7:0].
  - LOAD_I: 4 cycles at MODE_IN; pin_data = in bytes 0..3. The last byte is sampled at edge E, where E = 8 with weights or E = 4 without.
  - SETTLE: MODE_RD from edge E+1 onward. The convolution updates at E+1. The core read at edge E+2 captures the new result. At edge E+2 the driver latches exp_snap = exp_odd (value before that toggle).
  - CAPTURE: at edge E+3+PIN_LAT the driver samples the pins.
    - result <= pin_res_lo plus pin_res_hi[0], forming 9 bits.
    - parity_err <= (pin_res_hi[1] != exp_snap).
    - done pulses in the following cycle; busy drops with done; return to IDLE.
- Latency from the start edge to the done-registering edge: 11 + PIN_LAT with weights, 7 + PIN_LAT without.
- Arithmetic: the core exposes only conv[8:0], so results are modulo 512. No saturation; this is documented host behaviour.
- Boundary conditions:
  - start while busy is ignored and not queued.
  - start in the same cycle as done/return to IDLE is not accepted; it is accepted the next cycle.
  - in_vec, wt_vec and load_weights are registered at acceptance; later changes are ignored.
  - Reset mid-operation: immediate return to reset state; no done pulse. Core and driver parity realign because both clear odd.
  - load_weights = 0 before any weight load: the core's weights are 0 from reset, so result = 0 and parity_err = 0.

Decomposition:
- conv2x2_host_pkg holds:
  - mode constants MODE_IN, MODE_WT, MODE_RD;
  - state enum IDLE/LOAD_W/LOAD_I/SETTLE/CAPTURE;
  - NUM_TAPS = 4 and BYTE_W = 8;
  - RES_W = 9.
- One sub-module: conv2x2_byte_serializer. It takes a 32-bit load, emits 4 bytes LSB-first with a 2-bit counter, and signals last. It is instantiated once and reloaded with weights and then inputs.

Test Plan:
- in = {1,2,3,4}, wt = {5,6,7,8}, load_weights = 1, PIN_LAT = 0 -> done at edge 11, result = 70, parity_err = 0; pin_mode sequence 01 x4, 00 x4, then 10.
- Then load_weights = 0, in = {10,0,0,0} -> done at edge 7 after start, result = 50, weights unchanged.
- All bytes 255 in both vectors -> raw sum 260100 -> result = 4 (mod 512), parity_err = 0.
- Bench inverts pin_res_hi[1] during CAPTURE -> parity_err = 1, result still correct; next clean request -> parity_err = 0.
- PIN_LAT = 2 with delayed return-path model -> done at edge 13, result = 70.
- Assert rst_n = 0 during LOAD_I, release, then issue a clean request -> no done during the aborted request; clean request gives the correct result with parity_err = 0; start pulses while busy produce no extra done.
